// File: rtl/cpu_periph_subsystem.sv
// CPU bus fabric: decodes one 16-byte window to the built-in accumulator peripheral,
// forwards everything else to external peripheral 0, and muxes read data back.
module cpu_periph_subsystem #(
    parameter logic [31:0] BASE = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_cpu,
    input  logic [31:0] wdata_cpu,
    input  logic [3:0]  we_cpu,
    output logic [31:0] rdata_cpu,
    output logic [31:0] addr_per,
    output logic [31:0] wdata_per,
    output logic [3:0]  we_per,
    output logic [1:0]  ce,
    input  logic [31:0] rdata_per0
);

    localparam logic [1:0] OFF_SUM   = 2'd0;
    localparam logic [1:0] OFF_DATA  = 2'd1;
    localparam logic [1:0] OFF_COUNT = 2'd2;
    localparam logic [1:0] OFF_CTRL  = 2'd3;

    logic        hit;
    logic [31:0] byte_mask;
    logic [31:0] masked_wdata;
    logic        wr;
    logic [1:0]  offset;
    logic [31:0] sum;
    logic [31:0] count;
    logic [31:0] last;
    logic [31:0] rdata_per1;

    // Pass-throughs are unconditional; each peripheral qualifies with its own ce bit.
    assign addr_per  = addr_cpu;
    assign wdata_per = wdata_cpu;
    assign we_per    = we_cpu;

    assign hit = (addr_cpu[31:4] == BASE[31:4]);
    assign ce  = hit ? 2'b10 : 2'b01;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{we_per[i]}};
        end
    end

    assign masked_wdata = wdata_per & byte_mask;
    assign wr           = ce[1] && (we_per != 4'b0000);
    assign offset       = addr_per[3:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            count <= '0;
            last  <= '0;
        end else if (wr) begin
            case (offset)
                OFF_DATA: begin
                    sum   <= sum + masked_wdata;
                    count <= count + 32'd1;
                    last  <= masked_wdata;
                end
                OFF_COUNT: begin
                    count <= (count & ~byte_mask) | masked_wdata;
                end
                OFF_CTRL: begin
                    if (we_per[0] && wdata_per[0]) begin
                        sum   <= '0;
                        count <= '0;
                        last  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_per1 = '0;
        case (offset)
            OFF_SUM:   rdata_per1 = sum;
            OFF_DATA:  rdata_per1 = last;
            OFF_COUNT: rdata_per1 = count;
            default:   rdata_per1 = '0;
        endcase
    end

    always_comb begin
        rdata_cpu = '0;
        case (ce)
            2'b10:   rdata_cpu = rdata_per1;
            2'b01:   rdata_cpu = rdata_per0;
            default: rdata_cpu = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_periph_subsystem.sv
// Bench for cpu_periph_subsystem: directed accesses, a register-level model checked
// every cycle, and literal expectations for the key register values.
module tb_cpu_periph_subsystem;

    localparam logic [31:0] BASE = 32'h0000_0080;

    logic        clk;
    logic        reset;
    logic [31:0] addr_cpu;
    logic [31:0] wdata_cpu;
    logic [3:0]  we_cpu;
    logic [31:0] rdata_cpu;
    logic [31:0] addr_per;
    logic [31:0] wdata_per;
    logic [3:0]  we_per;
    logic [1:0]  ce;
    logic [31:0] rdata_per0;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // model state
    logic [31:0] m_sum   = 0;
    logic [31:0] m_count = 0;
    logic [31:0] m_last  = 0;

    cpu_periph_subsystem #(.BASE(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr_cpu   (addr_cpu),
        .wdata_cpu  (wdata_cpu),
        .we_cpu     (we_cpu),
        .rdata_cpu  (rdata_cpu),
        .addr_per   (addr_per),
        .wdata_per  (wdata_per),
        .we_per     (we_per),
        .ce         (ce),
        .rdata_per0 (rdata_per0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd16);
    endfunction

    function automatic logic [31:0] keep_bytes(input logic [31:0] v, input logic [3:0] we);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++)
            if (we[i]) r = r + (v & (32'hFF << (8*i)));
        return r;
    endfunction

    // model update at each rising edge
    always @(posedge clk) begin
        int unsigned reg_idx;
        logic [31:0] mw;
        if (reset) begin
            m_sum = 0; m_count = 0; m_last = 0;
        end else if (in_window(addr_cpu) && we_cpu != 4'd0) begin
            reg_idx = (addr_cpu - BASE) / 4;
            mw = keep_bytes(wdata_cpu, we_cpu);
            if (reg_idx == 1) begin
                m_sum = m_sum + mw;
                m_count = m_count + 1;
                m_last = mw;
            end else if (reg_idx == 2) begin
                m_count = mw + keep_bytes(m_count, ~we_cpu);
            end else if (reg_idx == 3 && we_cpu[0] && (wdata_cpu % 2 == 1)) begin
                m_sum = 0; m_count = 0; m_last = 0;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        int unsigned reg_idx;
        if (chk_en) begin
            if (in_window(addr_cpu)) begin
                reg_idx = (addr_cpu - BASE) / 4;
                exp_rd = (reg_idx == 0) ? m_sum : (reg_idx == 1) ? m_last :
                         (reg_idx == 2) ? m_count : 32'd0;
                check("cyc_ce", {30'd0, ce}, 32'd2);
            end else begin
                exp_rd = rdata_per0;
                check("cyc_ce", {30'd0, ce}, 32'd1);
            end
            check("cyc_rdata", rdata_cpu, exp_rd);
            check("cyc_addr_per", addr_per, addr_cpu);
            check("cyc_wdata_per", wdata_per, wdata_cpu);
            check("cyc_we_per", {28'd0, we_per}, {28'd0, we_cpu});
        end
    end

    // driver: apply one access just after a rising edge
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        @(posedge clk);
        #1;
        addr_cpu = a;
        wdata_cpu = d;
        we_cpu = we;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 32'd0, 4'd0);
        #1;
        check(name, rdata_cpu, exp);
    endtask

    initial begin
        reset = 1'b1;
        addr_cpu = BASE;
        wdata_cpu = 0;
        we_cpu = 0;
        rdata_per0 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;
        #1;
        check("reset_sum", rdata_cpu, 32'd0);
        check("reset_ce", {30'd0, ce}, 32'd2);
        rd_check("reset_last", BASE + 4, 32'd0);
        rd_check("reset_count", BASE + 8, 32'd0);

        drive(BASE + 4, 32'd1, 4'hF);
        drive(BASE + 4, 32'd2, 4'hF);
        drive(BASE + 4, 32'd3, 4'hF);
        rd_check("acc_sum", BASE + 0, 32'd6);
        rd_check("acc_count", BASE + 8, 32'd3);
        rd_check("acc_last", BASE + 4, 32'd3);
        rd_check("addr_lsb_ignored", BASE + 6, 32'd3);

        drive(BASE + 8, 32'd9, 4'hF);
        drive(BASE + 12, 32'd0, 4'hF);
        rd_check("count_written", BASE + 8, 32'd9);
        rd_check("ctrl0_no_effect", BASE + 0, 32'd6);
        rd_check("ctrl_reads_zero", BASE + 12, 32'd0);
        drive(BASE + 0, 32'd0, 4'hF);
        rd_check("sum_read_only", BASE + 0, 32'd6);

        drive(BASE + 8, 32'hAABB_CCDD, 4'b0100);
        rd_check("count_byte_merge", BASE + 8, 32'h00BB_0009);

        drive(BASE + 12, 32'd1, 4'h1);
        rd_check("clear_sum", BASE + 0, 32'd0);
        rd_check("clear_count", BASE + 8, 32'd0);
        rd_check("clear_last", BASE + 4, 32'd0);
        drive(BASE + 4, 32'hFFFF_FFFF, 4'hF);
        drive(BASE + 4, 32'd2, 4'hF);
        rd_check("sum_wrap", BASE + 0, 32'd1);

        drive(BASE + 4, 32'h1234_5678, 4'b0011);
        rd_check("be_sum", BASE + 0, 32'h0000_5679);
        rd_check("be_last", BASE + 4, 32'h0000_5678);
        rd_check("be_count", BASE + 8, 32'd3);

        drive(32'h0000_0100, 32'h0BAD_F00D, 4'hF);
        #1;
        check("ext_ce", {30'd0, ce}, 32'd1);
        check("ext_rdata", rdata_cpu, 32'hDEAD_BEEF);
        check("ext_addr_per", addr_per, 32'h0000_0100);
        check("ext_wdata_per", wdata_per, 32'h0BAD_F00D);
        check("ext_we_per", {28'd0, we_per}, 32'hF);
        drive(BASE + 16, 32'd7, 4'hF);
        #1;
        check("above_window_ce", {30'd0, ce}, 32'd1);
        drive(BASE - 4, 32'd7, 4'hF);
        #1;
        check("below_window_ce", {30'd0, ce}, 32'd1);
        rd_check("ext_no_sum_change", BASE + 0, 32'h0000_5679);
        rd_check("ext_no_count_change", BASE + 8, 32'd3);

        drive(BASE + 4, 32'd5, 4'hF);
        reset = 1'b1;
        drive(BASE + 0, 32'd0, 4'd0);
        reset = 1'b0;
        #1;
        check("reset_over_write", rdata_cpu, 32'd0);
        rd_check("reset_count_mid", BASE + 8, 32'd0);

        @(posedge clk);
        #1;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
